// File: rtl/vfu_pkg.sv
// Shared widths and default sizing for the vector functional unit CFU glue.
package vfu_pkg;
  localparam int VEX_DATA_WIDTH      = 32;
  localparam int INSN_WIDTH          = 32;
  localparam int VLEN                = 64;
  localparam int MEM_DATA_WIDTH      = 64;
  localparam int RSP_DEPTH_DEFAULT   = 4;
  localparam int RSP_LATENCY_DEFAULT = 2;
endpackage

// File: rtl/vfu_rsp_fifo.sv
// In-order response queue: registered storage, combinational head read,
// pointers carry an extra wrap bit so full and empty are distinguishable.
module vfu_rsp_fifo import vfu_pkg::*; #(
  parameter int DATA_WIDTH = VEX_DATA_WIDTH,
  parameter int DEPTH      = RSP_DEPTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full_o || rd_en);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/vfu_cmd_rsp_ctrl.sv
// CFU handshake stage: forwards commands to the vector core, captures each
// result a fixed latency after accept and returns it in order under credit.
module vfu_cmd_rsp_ctrl #(
  parameter int DATA_WIDTH = vfu_pkg::VEX_DATA_WIDTH,
  parameter int INSN_WIDTH = vfu_pkg::INSN_WIDTH,
  parameter int DEPTH      = vfu_pkg::RSP_DEPTH_DEFAULT,
  parameter int LATENCY    = vfu_pkg::RSP_LATENCY_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [INSN_WIDTH-1:0]        cmd_payload_instruction,
  output logic [INSN_WIDTH-1:0]        core_insn,
  output logic                         core_cmd_valid,
  input  logic                         core_cmd_ready,
  input  logic [DATA_WIDTH-1:0]        core_rsp_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_payload_output,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         overflow_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [LATENCY-1:0] pipe_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q;
  logic               credit, accept, pop, capture, drop;
  logic               q_empty, q_full;

  assign credit         = (cnt_q < FULL_CNT);
  assign cmd_ready      = core_cmd_ready & credit;
  assign core_cmd_valid = cmd_valid & credit;
  assign core_insn      = cmd_payload_instruction;
  assign accept         = cmd_valid & cmd_ready;

  assign rsp_valid      = !q_empty;
  assign pop            = rsp_valid & rsp_ready;
  assign capture        = pipe_q[LATENCY-1];
  assign drop           = capture & q_full & !pop;

  assign outstanding    = cnt_q;
  assign overflow_err   = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + ONE_CNT;
    else if (pop && !accept) cnt_d = cnt_q - ONE_CNT;
  end

  // Credit is returned from the registered count only, never combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pipe_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      cnt_q <= cnt_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  vfu_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (capture),
    .push_data_i (core_rsp_data),
    .pop_i       (pop),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (rsp_payload_output)
  );
endmodule

// File: tb/tb_vfu_cmd_rsp_ctrl.sv
// Directed and random stimulus against a queue-level model of command credit
// and fixed-latency in-order responses.
module tb_vfu_cmd_rsp_ctrl;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_payload_instruction;
  logic [31:0] core_insn;
  logic        core_cmd_valid;
  logic        core_cmd_ready;
  logic [31:0] core_rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_output;
  logic [2:0]  outstanding;
  logic        overflow_err;

  vfu_cmd_rsp_ctrl #(
    .DATA_WIDTH (32),
    .INSN_WIDTH (32),
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_instruction (cmd_payload_instruction),
    .core_insn               (core_insn),
    .core_cmd_valid          (core_cmd_valid),
    .core_cmd_ready          (core_cmd_ready),
    .core_rsp_data           (core_rsp_data),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_output      (rsp_payload_output),
    .outstanding             (outstanding),
    .overflow_err            (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: accepted-but-unanswered count, results waiting for the CPU, and
  // the cycle at which each in-flight command's result is taken from the core.
  int          cyc = 0;
  int          m_out = 0;
  int          next_id = 0;
  logic [31:0] rspq[$];
  int          cap_cyc[$];
  int          cap_id[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic cv, input logic ccr, input logic rr,
                      input logic auto_d, input logic [31:0] d);
    logic        cap, exp_rv, exp_cr, acc, pp;
    logic [31:0] exp_pl, dv, insn;
    @(negedge clk);
    cap  = (cap_cyc.size() > 0) && (cap_cyc[0] == cyc);
    dv   = (auto_d && cap) ? 32'(cap_id[0]) : d;
    insn = $urandom;
    cmd_valid               = cv;
    core_cmd_ready          = ccr;
    rsp_ready               = rr;
    core_rsp_data           = dv;
    cmd_payload_instruction = insn;
    #1;
    exp_rv = (rspq.size() > 0);
    exp_pl = exp_rv ? rspq[0] : 32'h0;
    exp_cr = ccr && (m_out < DEPTH);
    chk("core_insn", core_insn, insn);
    chk("cmd_ready", cmd_ready, exp_cr);
    chk("core_cmd_valid", core_cmd_valid, cv && (m_out < DEPTH));
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_payload", rsp_payload_output, exp_pl);
    chk("outstanding", outstanding, m_out);
    chk("overflow_err", overflow_err, 1'b0);
    acc = cv && exp_cr;
    pp  = exp_rv && rr;
    @(posedge clk);
    if (pp) void'(rspq.pop_front());
    if (cap) begin
      rspq.push_back(dv);
      void'(cap_cyc.pop_front());
      void'(cap_id.pop_front());
    end
    if (acc) begin
      cap_cyc.push_back(cyc + LATENCY);
      cap_id.push_back(next_id);
      next_id++;
      m_out++;
    end
    if (pp) m_out--;
    cyc++;
  endtask

  initial begin
    int drops;
    reset = 1'b1;
    cmd_valid = 1'b0;
    core_cmd_ready = 1'b1;
    rsp_ready = 1'b0;
    core_rsp_data = '0;
    cmd_payload_instruction = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_payload", rsp_payload_output, 32'h0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_overflow", overflow_err, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;

    // Single command, result 0xDEADBEEF two cycles after accept
    step(1, 1, 1, 0, $urandom);
    step(0, 1, 1, 0, $urandom);
    step(0, 1, 1, 0, 32'hDEADBEEF);
    step(0, 1, 1, 0, $urandom);
    step(0, 1, 1, 0, $urandom);

    // Backpressure fill: five commands, results 1..5, CPU stalled
    next_id = 1;
    for (int i = 0; i < 8; i++) step(next_id <= 5, 1, 0, 1, 32'h0);
    #2;
    chk("fill_outstanding", outstanding, DEPTH);
    chk("fill_cmd_ready", cmd_ready, 1'b0);
    chk("fill_head", rsp_payload_output, 32'h1);
    chk("fill_overflow", overflow_err, 1'b0);
    for (int i = 0; i < 10; i++) step(next_id <= 5, 1, 1, 1, 32'h0);

    // Full count with a pop landing on the same cycle as a pending push
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 32'h0);
    step(0, 1, 0, 1, 32'h0);
    step(0, 1, 1, 1, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 32'h0);

    // Core stall
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, $urandom);

    // Reset mid-operation: one result queued, two in flight
    step(1, 1, 0, 0, $urandom);
    step(0, 1, 0, 0, $urandom);
    step(1, 1, 0, 0, $urandom);
    step(1, 1, 0, 0, $urandom);
    #3;
    cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_payload", rsp_payload_output, 32'h0);
    rspq.delete();
    cap_cyc.delete();
    cap_id.delete();
    m_out = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, $urandom);
    step(1, 1, 1, 0, $urandom);
    step(0, 1, 1, 0, $urandom);
    step(0, 1, 1, 0, 32'hDEADBEEF);
    step(0, 1, 1, 0, $urandom);
    step(0, 1, 1, 0, $urandom);

    // Streaming: 16 back-to-back commands, results equal to index
    next_id = 0;
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 1, 1, 32'h0);
      #1;
      if (i < 15 && cmd_ready !== 1'b1) drops++;
    end
    chk("stream_no_drop", drops, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 32'h0);
    chk("stream_all_returned", 32'(next_id), 16);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), 0, $urandom);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, $urandom);
    #1;
    chk("final_outstanding", outstanding, 0);
    chk("final_rsp_valid", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vfu_cmd_rsp_ctrl.md
Name: vfu_cmd_rsp_ctrl

Overview:
- CFU-bus handshake stage between the VexRiscv CFU port and the vector unit core (the rvv_proc_main wrapper).
- Forwards commands to the core and tracks every accepted command.
- Captures the core's 32-bit result a fixed LATENCY cycles after acceptance and queues it in order.
- Drives a proper rsp_valid/rsp_ready response with credit-based backpressure, replacing the constant-high rsp_valid now in the Vfu top.

Parameters:
- DATA_WIDTH, 32, width of response payload (VEX data width).
- INSN_WIDTH, 32, width of instruction payload.
- DEPTH, 4, response queue entries and max outstanding commands; power of 2, >=2.
- LATENCY, 2, cycles from command accept to core result valid; >=1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_payload_instruction  in  INSN_WIDTH  passed through to core_insn.
- core_insn  out  INSN_WIDTH  instruction to core (combinational copy).
- core_cmd_valid  out  1  command valid to core.
- core_cmd_ready  in  1  core ready (proc_rdy).
- core_rsp_data  in  DATA_WIDTH  core result, valid LATENCY cycles after accept.
- rsp_valid  out  1  response valid to CPU.
- rsp_ready  in  1  CPU accepts response.
- rsp_payload_output  out  DATA_WIDTH  response data, head of queue.
- outstanding  out  $clog2(DEPTH+1)  accepted commands not yet responded.
- overflow_err  out  1  sticky; queue push while full.

Behaviour:
- Reset (async assert, sync release): pipe bits, queue pointers, outstanding, overflow_err all 0. rsp_valid=0, rsp_payload_output=0. In-flight commands are discarded; core results arriving after reset are ignored.
- credit = (outstanding < DEPTH).
- cmd_ready = core_cmd_ready & credit; core_cmd_valid = cmd_valid & credit; accept = cmd_valid & cmd_ready.
- Track pipe: LATENCY-bit shift register; bit0 <= accept each cycle.
  - Accept in cycle T: capture strobe high in cycle T+LATENCY; core_rsp_data is sampled at the end of that cycle and pushed to the queue.
  - rsp_valid is high from cycle T+LATENCY+1 (registered; no bypass).
  - Minimum accept-to-rsp_valid latency is LATENCY+1.
- Queue: DEPTH-entry FIFO, strict in-order.
  - pop = rsp_valid & rsp_ready.
  - rsp_valid = !empty; rsp_payload_output = head entry, held stable while rsp_valid & !rsp_ready.
  - Push and pop in the same cycle are both allowed when not empty (full or partly full); count unchanged.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- outstanding: +1 on accept, -1 on pop, unchanged when both occur. Never exceeds DEPTH, never underflows.
- Credit makes overflow impossible in correct use. If a push hits a full queue that is not popping in the same cycle, the data is dropped and overflow_err sets and stays set until reset.
- Pop on empty cannot occur, because rsp_valid is 0.
- Back-to-back accepts sustain 1 command/cycle while credit allows.
- When full (outstanding==DEPTH), cmd_ready is 0. A pop makes cmd_ready 1 in the next cycle (registered count); there is no same-cycle combinational credit return.

Decomposition:
- Package vfu_pkg:
  - VEX_DATA_WIDTH=32, INSN_WIDTH=32, VLEN=64, MEM_DATA_WIDTH=64 constants.
  - Default DEPTH and LATENCY constants.
- Sub-module vfu_rsp_fifo (DATA_WIDTH, DEPTH): push/pop/full/empty/head. Synchronous write, head read combinationally from the register array, async reset of pointers.
- Top keeps the track pipe, credit counter and error flag.

Test Plan (DEPTH=4, LATENCY=2):
- Single command: accept in cycle 0, core_rsp_data=0xDEADBEEF in cycle 2, rsp_ready=1 -> rsp_valid=1 with payload 0xDEADBEEF only in cycle 3; outstanding goes 0,1,1,1,0.
- Backpressure fill: 5 back-to-back cmd_valid, rsp_ready=0, results 0x1..0x5 -> 4 accepted, cmd_ready=0 from cycle 4, outstanding=4, overflow_err=0. Raise rsp_ready -> responses 0x1,0x2,0x3,0x4 in order. 5th command accepted the cycle after the first pop.
- Full plus simultaneous events: with outstanding=4 and a pop in the same cycle as a pending push -> count stays correct, no data loss, overflow_err=0.
- Core stall: core_cmd_ready=0 with cmd_valid=1 -> cmd_ready=0, no accept, outstanding unchanged.
- Reset mid-operation: 2 in flight plus 1 queued, reset pulsed asynchronously between edges -> rsp_valid=0 immediately, outstanding=0. Later core data is not pushed; the next command behaves as in the single-command scenario.
- Streaming: rsp_ready=1, 16 back-to-back commands with results equal to index -> 16 in-order responses, with cmd_ready never dropping.
